turf_event_gen: RTL and testbench

TURF_EVENT_GEN -- requirements
Module: turf_event_gen

---
 rtl/turf_event_gen.sv | 159 +++++++++++++++
 tb/tb_turf_event_gen.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_event_gen.sv
// Event frame generator: header, indexed payload words and an optional XOR trailer on an AXI4-stream master.
// Define TURF_EVENT_GEN_CHECKSUM_EN to append the checksum trailer word.
module turf_event_gen #(
  parameter logic [7:0]  MAGIC   = 8'hE5,
  parameter logic [11:0] MAX_LEN = 12'd1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        trig_i,
  input  logic [11:0] len_i,
  output logic        busy_o,
  output logic        drop_o,
  output logic [7:0]  drop_cnt_o,
  output logic [11:0] evnum_o,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
    , TRL = 2'd3
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] len_reg;
  logic [11:0] ev_reg;
  logic [11:0] k_reg;
  logic [11:0] evnum_reg;
  logic [7:0]  drop_cnt_reg;
  logic        drop_reg;
  logic        armed_reg;
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
  logic [31:0] csum_reg;
`endif

  logic beat;
  logic last_pay;
  logic accept;
  logic reject;
  logic ev_end;

  assign beat     = m_axis_tvalid && m_axis_tready;
  assign last_pay = (k_reg == len_reg - 12'd1);
  // armed_reg masks the first cycle after reset release
  assign accept   = trig_i && armed_reg && (state_reg == IDLE);
  assign reject   = trig_i && busy_o;
  assign ev_end   = beat && m_axis_tlast;

  assign drop_o     = drop_reg;
  assign drop_cnt_o = drop_cnt_reg;
  assign evnum_o    = evnum_reg;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = HDR;
      HDR: begin
        if (beat) begin
          if (len_reg != 12'd0) state_next = PAY;
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
          else state_next = TRL;
`else
          else state_next = IDLE;
`endif
        end
      end
      PAY: begin
        if (beat && last_pay) begin
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
          state_next = TRL;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
      TRL: if (beat) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = 32'd0;
    busy_o        = 1'b0;
    case (state_reg)
      HDR: begin
        m_axis_tvalid = 1'b1;
        busy_o        = 1'b1;
        m_axis_tdata  = {MAGIC, ev_reg, len_reg};
`ifndef TURF_EVENT_GEN_CHECKSUM_EN
        m_axis_tlast  = (len_reg == 12'd0);
`endif
      end
      PAY: begin
        m_axis_tvalid = 1'b1;
        busy_o        = 1'b1;
        m_axis_tdata  = {4'h0, ev_reg, 4'h0, k_reg};
`ifndef TURF_EVENT_GEN_CHECKSUM_EN
        m_axis_tlast  = last_pay;
`endif
      end
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
      TRL: begin
        m_axis_tvalid = 1'b1;
        busy_o        = 1'b1;
        m_axis_tdata  = csum_reg;
        m_axis_tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_reg      <= 12'd0;
      ev_reg       <= 12'd0;
      k_reg        <= 12'd0;
      evnum_reg    <= 12'd0;
      drop_cnt_reg <= 8'd0;
      drop_reg     <= 1'b0;
      armed_reg    <= 1'b0;
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
      csum_reg     <= 32'd0;
`endif
    end else begin
      armed_reg <= 1'b1;
      drop_reg  <= reject;
      if (reject && drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      if (accept) begin
        len_reg <= (len_i > MAX_LEN) ? MAX_LEN : len_i;
        ev_reg  <= evnum_reg;
        k_reg   <= 12'd0;
      end else if (beat && state_reg == PAY) begin
        k_reg <= k_reg + 12'd1;
      end
`ifdef TURF_EVENT_GEN_CHECKSUM_EN
      if (accept) csum_reg <= 32'd0;
      else if (beat && (state_reg == HDR || state_reg == PAY)) csum_reg <= csum_reg ^ m_axis_tdata;
`endif
      if (ev_end) evnum_reg <= evnum_reg + 12'd1;
    end
  end

endmodule

// File: tb/tb_turf_event_gen.sv
// Scoreboard bench for turf_event_gen: expected words queued at trigger time, popped by a beat monitor.
module tb_turf_event_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        trig_i;
  logic [11:0] len_i;
  logic        busy_o;
  logic        drop_o;
  logic [7:0]  drop_cnt_o;
  logic [11:0] evnum_o;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

`ifdef TURF_EVENT_GEN_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  turf_event_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trig_i        (trig_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .drop_o        (drop_o),
    .drop_cnt_o    (drop_cnt_o),
    .evnum_o       (evnum_o),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] ev_exp = 12'd0;
  int          ready_mode = 0;
  int          ready_phase = 0;
  logic [3:0]  ready_pat = 4'b1001;
  int          drop_seen = 0;
  int          beat_cnt = 0;
  logic [31:0] last_beat_data = 32'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  always begin
    @(posedge aclk);
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = ready_pat[ready_phase % 4];
        ready_phase++;
      end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Beat monitor: inputs change only at posedge+1, so negedge values are what the next edge samples
  always @(negedge aclk) begin
    word_t w;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h last=%b, need no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          w = exp_q.pop_front();
          if (m_axis_tdata !== w.data || m_axis_tlast !== w.last) begin
            errors++;
            $display("FAIL beat: got data=%h last=%b, need data=%h last=%b",
                     m_axis_tdata, m_axis_tlast, w.data, w.last);
          end
        end
        beat_cnt++;
        last_beat_data = m_axis_tdata;
      end
      if (drop_o === 1'b1) drop_seen++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic push_event(input logic [11:0] len, input logic [11:0] ev);
    word_t w;
    logic [31:0] csum;
    logic [15:0] k16;
    w.data = {8'hE5, ev, len};
    w.last = !CSUM && (len == 12'd0);
    csum = w.data;
    exp_q.push_back(w);
    for (int k = 0; k < int'(len); k++) begin
      k16 = 16'(k);
      w.data = {4'h0, ev, k16};
      w.last = !CSUM && (k == int'(len) - 1);
      csum ^= w.data;
      exp_q.push_back(w);
    end
    if (CSUM) begin
      w.data = csum;
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  // Call at posedge+1 with the DUT idle; returns at posedge+1 of the header cycle
  task automatic start_event(input logic [11:0] len_req);
    logic [11:0] elen;
    elen = (len_req > 12'd1024) ? 12'd1024 : len_req;
    push_event(elen, ev_exp);
    trig_i = 1'b1;
    len_i  = len_req;
    @(posedge aclk);
    #1;
    trig_i = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL latency: got valid=%b busy=%b, need valid=1 busy=1", m_axis_tvalid, busy_o);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((m_axis_tvalid || exp_q.size() != 0) && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL event_end: got valid=%b busy=%b pending=%0d after %0d cycles, need idle with 0 pending",
               m_axis_tvalid, busy_o, exp_q.size(), n);
      exp_q.delete();
    end
    ev_exp = ev_exp + 12'd1;
    checks++;
    if (evnum_o !== ev_exp) begin
      errors++;
      $display("FAIL evnum: got %h, need %h", evnum_o, ev_exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    trig_i  = 1'b0;
    len_i   = 12'd0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    ev_exp = 12'd0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    trig_i  = 1'b0;
    len_i   = 12'd0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_stream: got valid=%b last=%b data=%h, need 0 0 00000000",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++;
    if (busy_o !== 1'b0 || drop_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b drop=%b, need 0 0", busy_o, drop_o);
    end
    checks++;
    if (drop_cnt_o !== 8'd0 || evnum_o !== 12'd0) begin
      errors++;
      $display("FAIL reset_counts: got drop_cnt=%0d evnum=%h, need 0 000", drop_cnt_o, evnum_o);
    end
    // A trigger in the first cycle after release must be ignored
    aresetn = 1'b1;
    trig_i  = 1'b1;
    len_i   = 12'd5;
    @(posedge aclk);
    #1;
    trig_i = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle_trig: got valid=%b busy=%b, need 0 0", m_axis_tvalid, busy_o);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (drop_o !== 1'b0 || drop_cnt_o !== 8'd0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle_drop: got drop=%b cnt=%0d valid=%b, need 0 0 0", drop_o, drop_cnt_o, m_axis_tvalid);
    end
    ev_exp = 12'd0;
  endtask

  task automatic test_basic();
    ready_mode = 0;
    start_event(12'd3);
    wait_done(50);
    start_event(12'd1);
    wait_done(50);
  endtask

  task automatic test_len0();
    ready_mode = 0;
    start_event(12'd0);
    wait_done(20);
  endtask

  task automatic test_stall();
    int b0;
    ready_mode  = 1;
    ready_phase = 0;
    b0 = beat_cnt;
    start_event(12'd2);
    wait_done(100);
    checks++;
    if (beat_cnt - b0 != 3 + int'(CSUM)) begin
      errors++;
      $display("FAIL stall_beats: got %0d beats, need %0d", beat_cnt - b0, 3 + int'(CSUM));
    end
    ready_mode = 2;
    start_event(12'd7);
    wait_done(400);
    ready_mode = 0;
  endtask

  task automatic test_clamp();
    ready_mode = 0;
    start_event(12'd1024);
    wait_done(3000);
    start_event(12'd2000);
    wait_done(3000);
  endtask

  task automatic test_back_to_back();
    logic [7:0] cnt0;
    ready_mode = 0;
    cnt0 = drop_cnt_o;
    push_event(12'd0, ev_exp);
    trig_i = 1'b1;
    len_i  = 12'd0;
    @(posedge aclk);
    #1;
    // header-only event: this cycle is also its end cycle, so the held trigger is dropped
    @(posedge aclk);
    #1;
    trig_i = 1'b0;
    if (CSUM) begin
      @(posedge aclk);
      #1;
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || drop_cnt_o !== cnt0 + 8'd1) begin
      errors++;
      $display("FAIL end_cycle_drop: got valid=%b drop_cnt=%0d, need 0 %0d", m_axis_tvalid, drop_cnt_o, cnt0 + 8'd1);
    end
    wait_done(20);
    start_event(12'd1);
    wait_done(20);
  endtask

  task automatic test_drops();
    ready_mode = 0;
    drop_seen  = 0;
    start_event(12'd400);
    trig_i = 1'b1;
    len_i  = 12'd9;
    repeat (300) begin
      @(posedge aclk);
      #1;
    end
    trig_i = 1'b0;
    wait_done(1000);
    checks++;
    if (drop_seen != 300) begin
      errors++;
      $display("FAIL drop_pulses: got %0d, need 300", drop_seen);
    end
    checks++;
    if (drop_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL drop_sat: got %0d, need 255", drop_cnt_o);
    end
  endtask

  task automatic test_wrap();
    ready_mode = 0;
    do_reset();
    for (int i = 0; i < 4097; i++) begin
      start_event(12'd0);
      wait_done(20);
    end
    checks++;
    if (last_beat_data[23:12] !== 12'h000 || evnum_o !== 12'd1) begin
      errors++;
      $display("FAIL wrap: got last evnum field=%h evnum_o=%h, need 000 001", last_beat_data[23:12], evnum_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w5;
    ready_mode = 0;
    w5 = {4'h0, ev_exp, 16'd5};
    start_event(12'd10);
    repeat (6) begin
      @(posedge aclk);
      #1;
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w5) begin
      errors++;
      $display("FAIL mid_word5: got valid=%b data=%h, need 1 %h", m_axis_tvalid, m_axis_tdata, w5);
    end
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || evnum_o !== 12'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: got valid=%b last=%b evnum=%h busy=%b, need 0 0 000 0",
               m_axis_tvalid, m_axis_tlast, evnum_o, busy_o);
    end
    exp_q.delete();
    ev_exp  = 12'd0;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resume: got valid=%b, need 0", m_axis_tvalid);
    end
    start_event(12'd1);
    wait_done(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn       = 1'b0;
    trig_i        = 1'b0;
    len_i         = 12'd0;
    m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_clamp();
    test_back_to_back();
    test_drops();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
